// File: rtl/datapath_controller_if.sv
// Control/data bus between datapath_controller (master) and the datapath plus block RAM (slave).
interface datapath_controller_if;
    logic [15:0] memoryData;
    logic [15:0] aluResult;
    logic [15:0] instruction;
    logic [15:0] programCounter;
    logic        blockRamReadEnable;
    logic        blockRamWriteEnable;
    logic        registerFileWriteEnable;
    logic [1:0]  integerTypeSelectionLine;
    logic        reg2OrImmediateSelectionLine;
    logic        pcOrRegisterSelectionLine;
    logic        addressFromRegOrDecoderSelectionLine;
    logic        writeBackToRegRamOrALUSelectionLine;
    logic        pcOrAluOutputRamReadSelectionLine;
    logic [15:0] decoderRamWriteAddress;
    logic [3:0]  registerWriteAddress;
    logic        halted;

    modport master (
        input  memoryData,
        input  aluResult,
        output instruction,
        output programCounter,
        output blockRamReadEnable,
        output blockRamWriteEnable,
        output registerFileWriteEnable,
        output integerTypeSelectionLine,
        output reg2OrImmediateSelectionLine,
        output pcOrRegisterSelectionLine,
        output addressFromRegOrDecoderSelectionLine,
        output writeBackToRegRamOrALUSelectionLine,
        output pcOrAluOutputRamReadSelectionLine,
        output decoderRamWriteAddress,
        output registerWriteAddress,
        output halted
    );

    modport slave (
        output memoryData,
        output aluResult,
        input  instruction,
        input  programCounter,
        input  blockRamReadEnable,
        input  blockRamWriteEnable,
        input  registerFileWriteEnable,
        input  integerTypeSelectionLine,
        input  reg2OrImmediateSelectionLine,
        input  pcOrRegisterSelectionLine,
        input  addressFromRegOrDecoderSelectionLine,
        input  writeBackToRegRamOrALUSelectionLine,
        input  pcOrAluOutputRamReadSelectionLine,
        input  decoderRamWriteAddress,
        input  registerWriteAddress,
        input  halted
    );
endinterface

// File: rtl/datapath_controller.sv
// Multi-cycle fetch/decode/execute controller owning PC and IR; drives all datapath strobes and selects.
// Optional feature: define CTRL_JUMP_EN to decode opcode 0x4 / ext 0xC as JUMP (PC <- aluResult).
module datapath_controller #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic                  clock,
    input  logic                  reset,
    datapath_controller_if.master bus
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] FETCH  = 3'd1;
    localparam logic [2:0] DECODE = 3'd2;
    localparam logic [2:0] EXEC   = 3'd3;
    localparam logic [2:0] MEMWB  = 3'd4;
    localparam logic [2:0] HALT   = 3'd5;

    localparam logic [3:0] OP_RTYPE = 4'h0;
    localparam logic [3:0] OP_ISIGN = 4'h1;
    localparam logic [3:0] OP_IZERO = 4'h2;
    localparam logic [3:0] OP_MEM   = 4'h4;
    localparam logic [3:0] OP_STORD = 4'hC;
    localparam logic [3:0] OP_SYS   = 4'hF;

    localparam logic [3:0] EXT_LOAD = 4'h0;
    localparam logic [3:0] EXT_STOR = 4'h4;
    localparam logic [3:0] EXT_HALT = 4'hF;

    logic [2:0]  state;
    logic [2:0]  nextState;
    logic [15:0] pc;
    logic [15:0] pcNext;
    logic [15:0] ir;

    logic [3:0]  opcode;
    logic [3:0]  ext;
    logic        isAlu;
    logic        isLoad;
    logic        isStor;
    logic        isStord;
    logic        isHalt;
    logic        isJump;
    logic        immSelect;
    logic [1:0]  immType;

    assign opcode  = ir[15:12];
    assign ext     = ir[7:4];
    assign isAlu   = (opcode == OP_RTYPE) || (opcode == OP_ISIGN) || (opcode == OP_IZERO);
    assign isLoad  = (opcode == OP_MEM) && (ext == EXT_LOAD);
    assign isStor  = (opcode == OP_MEM) && (ext == EXT_STOR);
    assign isStord = (opcode == OP_STORD);
    assign isHalt  = (opcode == OP_SYS) && (ext == EXT_HALT);

`ifdef CTRL_JUMP_EN
    localparam logic [3:0] EXT_JUMP = 4'hC;
    assign isJump = (opcode == OP_MEM) && (ext == EXT_JUMP);
`else
    assign isJump = 1'b0;
`endif

    // Immediate formatting depends only on the opcode of the held instruction.
    always_comb begin
        immSelect = 1'b0;
        immType   = 2'b00;
        case (opcode)
            OP_ISIGN: begin
                immSelect = 1'b1;
                immType   = 2'b01;
            end
            OP_IZERO: begin
                immSelect = 1'b1;
                immType   = 2'b10;
            end
            default: ;
        endcase
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:   nextState = FETCH;
            FETCH:  nextState = DECODE;
            DECODE: nextState = EXEC;
            EXEC: begin
                if (isLoad)      nextState = MEMWB;
                else if (isHalt) nextState = HALT;
                else             nextState = FETCH;
            end
            MEMWB:  nextState = FETCH;
            HALT:   nextState = HALT;
            default: nextState = IDLE;
        endcase
    end

    // The PC moves on the edge leaving the last cycle of an instruction, so the next FETCH sees it.
    always_comb begin
        pcNext = pc;
        if (state == EXEC && !isLoad && !isHalt) begin
            pcNext = isJump ? bus.aluResult : pc + 16'd1;
        end else if (state == MEMWB) begin
            pcNext = pc + 16'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            pc    <= RESET_PC;
            ir    <= 16'h0000;
        end else begin
            state <= nextState;
            pc    <= pcNext;
            if (state == DECODE) begin
                ir <= bus.memoryData;
            end
        end
    end

    // Moore outputs: state and IR only, never memoryData or aluResult.
    // NOTE: every output gets a default before the case so no path can infer a latch.
    always_comb begin
        bus.blockRamReadEnable                   = 1'b0;
        bus.blockRamWriteEnable                  = 1'b0;
        bus.registerFileWriteEnable              = 1'b0;
        bus.integerTypeSelectionLine             = 2'b00;
        bus.reg2OrImmediateSelectionLine         = 1'b0;
        bus.pcOrRegisterSelectionLine            = 1'b0;
        bus.addressFromRegOrDecoderSelectionLine = 1'b0;
        bus.writeBackToRegRamOrALUSelectionLine  = 1'b0;
        bus.pcOrAluOutputRamReadSelectionLine    = 1'b0;
        case (state)
            FETCH: begin
                bus.blockRamReadEnable                = 1'b1;
                bus.pcOrAluOutputRamReadSelectionLine = 1'b1;
            end
            EXEC: begin
                bus.pcOrRegisterSelectionLine    = 1'b1;
                bus.reg2OrImmediateSelectionLine = immSelect;
                bus.integerTypeSelectionLine     = immType;
                if (isAlu) begin
                    bus.registerFileWriteEnable             = 1'b1;
                    bus.writeBackToRegRamOrALUSelectionLine = 1'b1;
                end else if (isLoad) begin
                    bus.blockRamReadEnable = 1'b1;
                end else if (isStor) begin
                    bus.blockRamWriteEnable = 1'b1;
                end else if (isStord) begin
                    bus.blockRamWriteEnable                  = 1'b1;
                    bus.addressFromRegOrDecoderSelectionLine = 1'b1;
                end
            end
            MEMWB: begin
                bus.pcOrRegisterSelectionLine    = 1'b1;
                bus.reg2OrImmediateSelectionLine = immSelect;
                bus.integerTypeSelectionLine     = immType;
                bus.registerFileWriteEnable      = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.instruction            = ir;
    assign bus.programCounter         = pc;
    assign bus.decoderRamWriteAddress = {8'h00, ir[7:0]};
    assign bus.registerWriteAddress   = ir[11:8];
    assign bus.halted                 = (state == HALT);
endmodule

// File: doc/datapath_controller.md
# datapath_controller

Multi-cycle control unit sitting directly upstream of the datapath. Owns the program counter and instruction register. Fetches 16-bit instruction words from block RAM and decodes them. Sequences every datapath enable and mux select line so each instruction executes in 3 or 4 clocks.

## Interface
Parameters:
- RESET_PC, 16'h0000, program counter value loaded on reset.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- memoryData  in  16  block RAM read port (q); valid the cycle after a read-enabled cycle.
- aluResult  in  16  datapath ALU output; used only for JUMP.
- instruction  out  16  instruction register contents, fed to the datapath.
- programCounter  out  16  current PC.
- blockRamReadEnable  out  1  RAM read strobe.
- blockRamWriteEnable  out  1  RAM write strobe.
- registerFileWriteEnable  out  1  register file write strobe.
- integerTypeSelectionLine  out  2  immediate format: 00 raw, 01 sign-extend, 10 zero-extend.
- reg2OrImmediateSelectionLine  out  1  ALU B input: 0 reg2, 1 immediate.
- pcOrRegisterSelectionLine  out  1  ALU A input: 0 PC, 1 reg1.
- addressFromRegOrDecoderSelectionLine  out  1  RAM write address: 0 reg2, 1 decoderRamWriteAddress.
- writeBackToRegRamOrALUSelectionLine  out  1  register write data: 0 RAM, 1 ALU.
- pcOrAluOutputRamReadSelectionLine  out  1  RAM read address: 0 ALU, 1 PC.
- decoderRamWriteAddress  out  16  {8'h00, instruction[7:0]}, continuously driven.
- registerWriteAddress  out  4  instruction[11:8], continuously driven.
- halted  out  1  high while in HALT.

## Operation
Opcode is instruction[15:12]; ext is instruction[7:4].
- 0x0 R-type: ALU on reg1 and reg2; result written to Rdest.
- 0x1 I-type, sign-extended imm8; 0x2 I-type, zero-extended imm8. Result written to Rdest.
- 0x4 with ext 0x0 LOAD: Rdest <- mem[ALU].
- 0x4 with ext 0x4 STOR: mem[reg2] <- ALU.
- 0xC STORD: mem[zext imm8] <- ALU.
- 0xF with ext 0xF HALT.
- All other encodings are NOPs: no writes, PC advances.

States and transitions:
- IDLE -> FETCH unconditionally.
- FETCH: re=1, read select=1 (PC) -> DECODE.
- DECODE: IR <- memoryData -> EXEC.
- EXEC, R/I-type: select=ALU write-back, registerFileWriteEnable=1, PC+1 -> FETCH.
- EXEC, LOAD: re=1, read select=0 -> MEMWB.
- MEMWB: write-back select=0 (RAM), registerFileWriteEnable=1, PC+1 -> FETCH.
- EXEC, STOR/STORD: we=1, write-address select 0 (STOR) or 1 (STORD), PC+1 -> FETCH.
- EXEC, HALT: -> HALT.
- HALT: sticky; all enables 0; PC holds. Exited only by reset.

Select lines in EXEC and MEMWB:
- pcOrRegisterSelectionLine=1.
- reg2OrImmediateSelectionLine=1 only for opcodes 0x1 and 0x2.
- integerTypeSelectionLine=01 for 0x1, 10 for 0x2, 00 otherwise.

Other rules:
- Outputs are Moore-style: decoded from state and IR only, with no combinational path from memoryData or aluResult.
- PC arithmetic is 16-bit; 16'hFFFF + 1 wraps to 16'h0000.
- In IDLE, FETCH and DECODE, write enables are 0.

## Timing
- Reset, asynchronous: state=IDLE, PC=RESET_PC, IR=16'h0000. Every 1-bit output and integerTypeSelectionLine are 0; halted=0.
- First FETCH occurs on the second rising edge after reset deasserts.
- Latency: R/I/NOP/STOR/STORD take 3 cycles (FETCH, DECODE, EXEC). LOAD takes 4 cycles. A JUMP takes 3 cycles.
- PC updates on the edge that leaves EXEC or MEMWB, so the next FETCH uses the new PC.
- Reset asserted mid-instruction aborts immediately; no partial write occurs after assertion.
- At most one of re, we and registerFileWriteEnable asserts per cycle, except that MEMWB asserts only registerFileWriteEnable.

## Configuration
- CTRL_JUMP_EN defined: opcode 0x4 with ext 0xC is JUMP. In EXEC: pcOrRegisterSelectionLine=1, no write enables, PC <- aluResult (datapath passes reg1), then FETCH.
- CTRL_JUMP_EN undefined: that encoding is a NOP (PC+1).

## Test plan
- Reset released, RAM[0]=16'h0123 (R-type): outputs 0 during IDLE; FETCH re=1 on the 2nd edge; IR=16'h0123 after DECODE; registerFileWriteEnable=1 in EXEC only; PC=1 after 3 cycles.
- RAM[0]=16'h15FF (sign-ext imm): in EXEC, integerTypeSelectionLine=01, reg2OrImmediateSelectionLine=1, registerWriteAddress=5. Repeat with 16'h25FF: integerTypeSelectionLine=10.
- LOAD 16'h4302: EXEC has re=1 with read select=0; MEMWB has write-back select=0 and registerFileWriteEnable=1; PC+1 after 4 cycles. STORD 16'hC1A5: we=1, addressFromRegOrDecoderSelectionLine=1, decoderRamWriteAddress=16'h00A5.
- PC preloaded to 16'hFFFF with a NOP: next PC=16'h0000. HALT 16'hF0F0: halted=1 and PC frozen for 10 cycles; reset returns to IDLE.
- Reset pulsed low during an EXEC of STOR: we drops asynchronously, RAM is unchanged, PC=RESET_PC.
- With CTRL_JUMP_EN, 16'h40C0 and aluResult=16'h0040: next FETCH address is 16'h0040. Without it, the next FETCH address is PC+1.
